// File: rtl/vreg_bank_stream.sv
// Vector register bank loaded over a streaming write port.
// Commands (single, group, full, clear) are taken in IDLE; write beats are
// taken in WDATA. Offers a registered random-read port and a direct
// monitor view of every register.
module vreg_bank_stream #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int BUS_W    = 128,
    parameter int GROUP    = 4,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [BUS_W-1:0]             wdata,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [NUM_REGS*DATA_W-1:0]   mon_bank
);

    localparam int EPB    = BUS_W / DATA_W;
    localparam int BEATS  = NUM_REGS * DATA_W / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [2:0] OP_SINGLE = 3'b000;
    localparam logic [2:0] OP_GROUP  = 3'b001;
    localparam logic [2:0] OP_FULL   = 3'b010;
    localparam logic [2:0] OP_CLEAR  = 3'b011;

    typedef enum logic {IDLE, WDATA} state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic cmd_fire;
    logic beat_fire;
    logic last_beat;
    logic clear_fire;

    assign cmd_ready  = (state == IDLE);
    assign wready     = (state == WDATA);
    assign busy       = (state != IDLE);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign beat_fire  = wvalid && wready;
    assign clear_fire = cmd_fire && (cmd_op == OP_CLEAR);
    // Single and group transfers are one beat; full runs for BEATS beats.
    assign last_beat  = beat_fire &&
                        ((op_q != OP_FULL) || (beat_cnt == BEAT_W'(BEATS - 1)));

    // Command/beat sequencing with registered done/err pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= OP_SINGLE;
            addr_q   <= '0;
            beat_cnt <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        op_q     <= cmd_op;
                        addr_q   <= cmd_addr;
                        beat_cnt <= '0;
                        case (cmd_op)
                            OP_SINGLE, OP_GROUP, OP_FULL: state <= WDATA;
                            OP_CLEAR:                     done  <= 1'b1;
                            default:                      err   <= 1'b1;
                        endcase
                    end
                end
                WDATA: begin
                    if (last_beat) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (beat_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register file update: clear, or scatter the accepted beat by mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (clear_fire) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (beat_fire) begin
            case (op_q)
                OP_SINGLE: regs[addr_q] <= wdata[DATA_W-1:0];
                OP_GROUP: begin
                    // Index arithmetic is ADDR_W wide, so it wraps at NUM_REGS.
                    for (int k = 0; k < GROUP; k++)
                        regs[addr_q + ADDR_W'(k)] <= wdata[k*DATA_W +: DATA_W];
                end
                OP_FULL: begin
                    for (int k = 0; k < EPB; k++)
                        regs[ADDR_W'(int'(beat_cnt) * EPB + k)] <= wdata[k*DATA_W +: DATA_W];
                end
                default: ;
            endcase
        end
    end

    // Registered read; a same-cycle write is seen on the following read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data <= '0;
        else        rd_data <= regs[rd_addr];
    end

    // Monitor view is a direct flattening of the registers.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_mon
        assign mon_bank[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_vreg_bank_stream.sv
// Directed bench for vreg_bank_stream at default parameters.
module tb_vreg_bank_stream;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int BUS_W    = 128;
    localparam int ADDR_W   = 4;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [2:0]                 cmd_op;
    logic [ADDR_W-1:0]          cmd_addr;
    logic                       wvalid;
    logic                       wready;
    logic [BUS_W-1:0]           wdata;
    logic [ADDR_W-1:0]          rd_addr;
    logic [DATA_W-1:0]          rd_data;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic [NUM_REGS*DATA_W-1:0] mon_bank;

    int errors = 0;
    int checks = 0;

    vreg_bank_stream #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BUS_W(BUS_W), .GROUP(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .mon_bank(mon_bank)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mreg(input int i);
        return mon_bank[i*DATA_W +: DATA_W];
    endfunction

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_addr = '0;
        wvalid = 1'b0; wdata = '0; rd_addr = '0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        step();

        // 1: reset in the middle of a full load
        cmd_valid = 1'b1; cmd_op = 3'b010;
        step();
        cmd_valid = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_wready", wready, 1);
        wvalid = 1'b1; wdata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        step();
        chk("t1_reg0_beat0", mreg(0), 32'hA0);
        chk("t1_reg3_beat0", mreg(3), 32'hA3);
        reset = 1'b0;
        #1;
        for (int i = 0; i < NUM_REGS; i++) chk($sformatf("t1_rst_reg%0d", i), mreg(i), 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_cmd_ready", cmd_ready, 1);
        chk("t1_rst_rd_data", rd_data, 0);
        step();
        reset = 1'b1;
        wdata = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        step(); step();
        chk("t1_no_resume_wready", wready, 0);
        chk("t1_no_resume_done", done, 0);
        chk("t1_no_resume_reg4", mreg(4), 0);
        wvalid = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_addr = ADDR_W'(i);
            step();
            chk($sformatf("t1_rd%0d", i), rd_data, 0);
        end

        // 2: single write to register 5; cmd_addr change after acceptance ignored
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_addr = 4'd5;
        step();
        cmd_valid = 1'b0; cmd_addr = 4'd9;
        wvalid = 1'b1; wdata = {32'h3, 32'h2, 32'h1, 32'hDEADBEEF};
        step();
        wvalid = 1'b0;
        chk("t2_reg5", mreg(5), 32'hDEADBEEF);
        chk("t2_reg9", mreg(9), 0);
        chk("t2_reg6", mreg(6), 0);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        rd_addr = 4'd5;
        step();
        chk("t2_done_pulse", done, 0);
        chk("t2_rd5", rd_data, 32'hDEADBEEF);

        // 3: group load wrapping from 14 to 1
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_addr = 4'd14;
        step();
        cmd_valid = 1'b0;
        wvalid = 1'b1; wdata = {32'h44, 32'h33, 32'h22, 32'h11};
        step();
        wvalid = 1'b0;
        chk("t3_reg14", mreg(14), 32'h11);
        chk("t3_reg15", mreg(15), 32'h22);
        chk("t3_reg0", mreg(0), 32'h33);
        chk("t3_reg1", mreg(1), 32'h44);
        chk("t3_reg2", mreg(2), 0);
        chk("t3_reg13", mreg(13), 0);
        chk("t3_reg5", mreg(5), 32'hDEADBEEF);
        chk("t3_done", done, 1);

        // 4: full load, gaps before every beat, element value = index
        cmd_valid = 1'b1; cmd_op = 3'b010;
        step();
        cmd_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g <= b; g++) begin
                step();
                chk($sformatf("t4_gap_done_b%0d", b), done, 0);
            end
            wvalid = 1'b1;
            wdata = {32'(4*b+3), 32'(4*b+2), 32'(4*b+1), 32'(4*b)};
            step();
            wvalid = 1'b0;
            chk($sformatf("t4_done_b%0d", b), done, (b == 3) ? 1 : 0);
            chk($sformatf("t4_busy_b%0d", b), busy, (b == 3) ? 0 : 1);
        end
        for (int i = 0; i < NUM_REGS; i++) chk($sformatf("t4_reg%0d", i), mreg(i), i);
        // wvalid while IDLE must not write anything
        wvalid = 1'b1; wdata = {4{32'hFFFF_FFFF}};
        step();
        wvalid = 1'b0;
        chk("t4_idle_wvalid_reg0", mreg(0), 0);
        chk("t4_idle_wvalid_done", done, 0);

        // 5: clear, then an illegal op
        cmd_valid = 1'b1; cmd_op = 3'b011;
        step();
        cmd_valid = 1'b0;
        chk("t5_clr_done", done, 1);
        chk("t5_clr_busy", busy, 0);
        for (int i = 0; i < NUM_REGS; i++) chk($sformatf("t5_clr_reg%0d", i), mreg(i), 0);
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_addr = 4'd3;
        step();
        cmd_valid = 1'b0;
        wvalid = 1'b1; wdata = {96'h0, 32'h55};
        step();
        wvalid = 1'b0;
        chk("t5_reg3_pre", mreg(3), 32'h55);
        cmd_valid = 1'b1; cmd_op = 3'b111;
        step();
        cmd_valid = 1'b0;
        chk("t5_ill_err", err, 1);
        chk("t5_ill_done", done, 0);
        chk("t5_ill_reg3", mreg(3), 32'h55);
        chk("t5_ill_busy", busy, 0);
        step();
        chk("t5_ill_err_pulse", err, 0);

        // 6: back-to-back commands with a read of the register being written
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_addr = 4'd3;
        step();
        cmd_addr = 4'd7;
        chk("t6_cmd_ready_wait", cmd_ready, 0);
        step();
        chk("t6_still_busy", busy, 1);
        wvalid = 1'b1; wdata = {96'h0, 32'h66}; rd_addr = 4'd3;
        step();
        wvalid = 1'b0;
        chk("t6_rd_old", rd_data, 32'h55);
        chk("t6_reg3_new", mreg(3), 32'h66);
        chk("t6_done1", done, 1);
        chk("t6_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("t6_rd_new", rd_data, 32'h66);
        chk("t6_cmd2_busy", busy, 1);
        chk("t6_cmd2_done", done, 0);
        wvalid = 1'b1; wdata = {96'h0, 32'h77};
        step();
        wvalid = 1'b0;
        chk("t6_reg7", mreg(7), 32'h77);
        chk("t6_reg3_keep", mreg(3), 32'h66);
        chk("t6_done2", done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
